// File: rtl/execute_pipe_stage_pkg.sv
// Shared pipeline definitions: ALU opcodes, forward-select codes and
// default datapath widths used by the execute stage and its ALU.
package execute_pipe_stage_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Operand source selects from the hazard unit; 2'b11 falls back to
    // the register-file value.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/execute_pipe_stage_alu.sv
// Combinational ALU for the execute stage.
// Ports: i_a, i_b operands; i_ctrl opcode; o_y result (unknown codes -> 0).
module alu
    import execute_pipe_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    input  logic [2:0]            i_ctrl,
    output logic [DATA_WIDTH-1:0] o_y
);

    logic w_lt;

    assign w_lt = $signed(i_a) < $signed(i_b);

    always_comb begin
        o_y = '0;
        case (i_ctrl)
            ALU_AND: o_y = i_a & i_b;
            ALU_OR:  o_y = i_a | i_b;
            ALU_ADD: o_y = i_a + i_b;
            ALU_SUB: o_y = i_a - i_b;
            ALU_SLT: o_y = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/execute_pipe_stage.sv
// Execute stage: ID/EX register, operand forwarding muxes, ALU and EX/MEM.
// Ports: CLK/RST, FlushE, ForwardAE/BE, D-stage operands and control,
// ResultW in; E-stage hazard info and M-stage results out.
module execute_pipe_stage
    import execute_pipe_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      FlushE,
    input  logic [1:0]                ForwardAE,
    input  logic [1:0]                ForwardBE,
    input  logic [DATA_WIDTH-1:0]     RD1D,
    input  logic [DATA_WIDTH-1:0]     RD2D,
    input  logic [DATA_WIDTH-1:0]     SignImmD,
    input  logic [REG_ADDR_WIDTH-1:0] RsD,
    input  logic [REG_ADDR_WIDTH-1:0] RtD,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic                      RegWriteD,
    input  logic                      MemtoRegD,
    input  logic                      MemWriteD,
    input  logic                      ALUSrcD,
    input  logic                      RegDstD,
    input  logic [2:0]                ALUControlD,
    input  logic [DATA_WIDTH-1:0]     ResultW,
    output logic [REG_ADDR_WIDTH-1:0] RsE,
    output logic [REG_ADDR_WIDTH-1:0] RtE,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegE,
    output logic                      RegWriteE,
    output logic                      MemtoRegE,
    output logic [DATA_WIDTH-1:0]     ALUOutM,
    output logic [DATA_WIDTH-1:0]     WriteDataM,
    output logic [REG_ADDR_WIDTH-1:0] WriteRegM,
    output logic                      RegWriteM,
    output logic                      MemtoRegM,
    output logic                      MemWriteM
);

    // ID/EX
    logic [DATA_WIDTH-1:0]     r_rd1_e;
    logic [DATA_WIDTH-1:0]     r_rd2_e;
    logic [DATA_WIDTH-1:0]     r_imm_e;
    logic [REG_ADDR_WIDTH-1:0] r_rs_e;
    logic [REG_ADDR_WIDTH-1:0] r_rt_e;
    logic [REG_ADDR_WIDTH-1:0] r_rd_e;
    logic                      r_regwrite_e;
    logic                      r_memtoreg_e;
    logic                      r_memwrite_e;
    logic                      r_alusrc_e;
    logic                      r_regdst_e;
    logic [2:0]                r_aluctrl_e;

    // EX/MEM
    logic [DATA_WIDTH-1:0]     r_aluout_m;
    logic [DATA_WIDTH-1:0]     r_wdata_m;
    logic [REG_ADDR_WIDTH-1:0] r_wreg_m;
    logic                      r_regwrite_m;
    logic                      r_memtoreg_m;
    logic                      r_memwrite_m;

    logic [DATA_WIDTH-1:0]     w_src_a;
    logic [DATA_WIDTH-1:0]     w_wdata_e;
    logic [DATA_WIDTH-1:0]     w_src_b;
    logic [DATA_WIDTH-1:0]     w_aluout_e;
    logic [REG_ADDR_WIDTH-1:0] w_wreg_e;

    // A flush loads an all-zero bubble; its zero ALU opcode (AND of
    // zeros) keeps the bubble's data path quiet as well.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || FlushE) begin
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_e      <= '0;
            r_rs_e       <= '0;
            r_rt_e       <= '0;
            r_rd_e       <= '0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_memwrite_e <= 1'b0;
            r_alusrc_e   <= 1'b0;
            r_regdst_e   <= 1'b0;
            r_aluctrl_e  <= '0;
        end else begin
            r_rd1_e      <= RD1D;
            r_rd2_e      <= RD2D;
            r_imm_e      <= SignImmD;
            r_rs_e       <= RsD;
            r_rt_e       <= RtD;
            r_rd_e       <= RdD;
            r_regwrite_e <= RegWriteD;
            r_memtoreg_e <= MemtoRegD;
            r_memwrite_e <= MemWriteD;
            r_alusrc_e   <= ALUSrcD;
            r_regdst_e   <= RegDstD;
            r_aluctrl_e  <= ALUControlD;
        end
    end

    always_comb begin
        w_src_a = r_rd1_e;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = r_aluout_m;
            default: w_src_a = r_rd1_e;
        endcase
    end

    always_comb begin
        w_wdata_e = r_rd2_e;
        case (ForwardBE)
            FWD_WB:  w_wdata_e = ResultW;
            FWD_MEM: w_wdata_e = r_aluout_m;
            default: w_wdata_e = r_rd2_e;
        endcase
    end

    assign w_src_b  = r_alusrc_e ? r_imm_e : w_wdata_e;
    assign w_wreg_e = r_regdst_e ? r_rd_e : r_rt_e;

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .i_a    (w_src_a),
        .i_b    (w_src_b),
        .i_ctrl (r_aluctrl_e),
        .o_y    (w_aluout_e)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_aluout_m   <= '0;
            r_wdata_m    <= '0;
            r_wreg_m     <= '0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_memwrite_m <= 1'b0;
        end else begin
            r_aluout_m   <= w_aluout_e;
            r_wdata_m    <= w_wdata_e;
            r_wreg_m     <= w_wreg_e;
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_memwrite_m <= r_memwrite_e;
        end
    end

    assign RsE        = r_rs_e;
    assign RtE        = r_rt_e;
    assign WriteRegE  = w_wreg_e;
    assign RegWriteE  = r_regwrite_e;
    assign MemtoRegE  = r_memtoreg_e;
    assign ALUOutM    = r_aluout_m;
    assign WriteDataM = r_wdata_m;
    assign WriteRegM  = r_wreg_m;
    assign RegWriteM  = r_regwrite_m;
    assign MemtoRegM  = r_memtoreg_m;
    assign MemWriteM  = r_memwrite_m;

endmodule

// File: tb/tb_execute_pipe_stage.sv
// Directed bench for execute_pipe_stage: ALU vector table plus
// forwarding, flush and asynchronous-reset sequences.
module tb_execute_pipe_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] RD1D, RD2D, SignImmD, ResultW;
    logic [4:0]  RsD, RtD, RdD;
    logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
    logic [2:0]  ALUControlD;
    logic [4:0]  RsE, RtE, WriteRegE, WriteRegM;
    logic        RegWriteE, MemtoRegE;
    logic [31:0] ALUOutM, WriteDataM;
    logic        RegWriteM, MemtoRegM, MemWriteM;

    int n_total = 0;
    int n_pass  = 0;

    execute_pipe_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .FlushE      (FlushE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .SignImmD    (SignImmD),
        .RsD         (RsD),
        .RtD         (RtD),
        .RdD         (RdD),
        .RegWriteD   (RegWriteD),
        .MemtoRegD   (MemtoRegD),
        .MemWriteD   (MemWriteD),
        .ALUSrcD     (ALUSrcD),
        .RegDstD     (RegDstD),
        .ALUControlD (ALUControlD),
        .ResultW     (ResultW),
        .RsE         (RsE),
        .RtE         (RtE),
        .WriteRegE   (WriteRegE),
        .RegWriteE   (RegWriteE),
        .MemtoRegE   (MemtoRegE),
        .ALUOutM     (ALUOutM),
        .WriteDataM  (WriteDataM),
        .WriteRegM   (WriteRegM),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .MemWriteM   (MemWriteM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        alusrc;
        logic [2:0]  ctrl;
        logic        regdst;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] exp_alu;
        logic [4:0]  exp_wreg;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_d(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic regw, input logic m2r,
                         input logic memw, input logic alusrc,
                         input logic regdst, input logic [2:0] ctrl);
        RD1D = a; RD2D = b; SignImmD = imm;
        RsD = rs; RtD = rt; RdD = rd;
        RegWriteD = regw; MemtoRegD = m2r; MemWriteD = memw;
        ALUSrcD = alusrc; RegDstD = regdst; ALUControlD = ctrl;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ALUOutM"}, ALUOutM, 0);
        chk({tag, " WriteDataM"}, WriteDataM, 0);
        chk({tag, " WriteRegM"}, {27'd0, WriteRegM}, 0);
        chk({tag, " RegWriteM"}, {31'd0, RegWriteM}, 0);
        chk({tag, " MemtoRegM"}, {31'd0, MemtoRegM}, 0);
        chk({tag, " MemWriteM"}, {31'd0, MemWriteM}, 0);
        chk({tag, " RsE"}, {27'd0, RsE}, 0);
        chk({tag, " RtE"}, {27'd0, RtE}, 0);
        chk({tag, " WriteRegE"}, {27'd0, WriteRegE}, 0);
        chk({tag, " RegWriteE"}, {31'd0, RegWriteE}, 0);
        chk({tag, " MemtoRegE"}, {31'd0, MemtoRegE}, 0);
    endtask

    initial begin
        //         a             b             imm  src ctrl    dst rt  rd  exp_alu       wreg
        vecs[0]  = '{32'd5,        32'd7,        0,   0, 3'b010, 1, 2,  9,  32'd12,       9};
        vecs[1]  = '{32'hFFFFFFFF, 32'd1,        0,   0, 3'b111, 0, 4,  6,  32'd1,        4};
        vecs[2]  = '{32'd0,        32'd1,        0,   0, 3'b110, 1, 1,  3,  32'hFFFFFFFF, 3};
        vecs[3]  = '{32'h0000F0F0, 32'h00000FF0, 0,   0, 3'b000, 1, 0,  10, 32'h000000F0, 10};
        vecs[4]  = '{32'h0000F0F0, 32'h00000FF0, 0,   0, 3'b001, 0, 11, 12, 32'h0000FFF0, 11};
        vecs[5]  = '{32'd1,        32'hFFFFFFFF, 0,   0, 3'b111, 1, 0,  13, 32'd0,        13};
        vecs[6]  = '{32'hFFFFFFFF, 32'd1,        0,   0, 3'b010, 1, 0,  14, 32'd0,        14};
        vecs[7]  = '{32'd20,       32'd55,       100, 1, 3'b010, 0, 15, 16, 32'd120,      15};
        vecs[8]  = '{32'd5,        32'd3,        0,   0, 3'b011, 1, 0,  17, 32'd0,        17};
        vecs[9]  = '{32'h80000000, 32'd1,        0,   0, 3'b110, 1, 0,  31, 32'h7FFFFFFF, 31};
        vecs[10] = '{32'd9,        32'd4,        0,   0, 3'b100, 0, 18, 19, 32'd0,        18};

        RST = 1'b1; FlushE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        #1;
        chk_all_zero("reset");
        step();
        RST = 1'b0;

        foreach (vecs[i]) begin
            set_d(vecs[i].a, vecs[i].b, vecs[i].imm, 5'd1, vecs[i].rt,
                  vecs[i].rd, 1, 0, 0, vecs[i].alusrc, vecs[i].regdst,
                  vecs[i].ctrl);
            step();
            set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
            step();
            chk($sformatf("vec%0d ALUOutM", i), ALUOutM, vecs[i].exp_alu);
            chk($sformatf("vec%0d WriteRegM", i), {27'd0, WriteRegM},
                {27'd0, vecs[i].exp_wreg});
            chk($sformatf("vec%0d WriteDataM", i), WriteDataM, vecs[i].b);
            chk($sformatf("vec%0d RegWriteM", i), {31'd0, RegWriteM}, 1);
        end

        // Back-to-back dependency through the EX/MEM forward path.
        set_d(10, 20, 0, 1, 2, 8, 1, 0, 0, 0, 1, 3'b010);
        step();
        set_d(32'hBAD, 5, 0, 8, 3, 9, 1, 0, 0, 0, 1, 3'b010);
        step();
        chk("fwdA first ALUOutM", ALUOutM, 30);
        chk("fwdA WriteRegE", {27'd0, WriteRegE}, 9);
        chk("fwdA RsE", {27'd0, RsE}, 8);
        ForwardAE = 2'b10;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        step();
        ForwardAE = 2'b00;
        chk("fwdA second ALUOutM", ALUOutM, 35);
        chk("fwdA second WriteRegM", {27'd0, WriteRegM}, 9);

        // Store with both operands taken from the writeback result.
        set_d(4, 32'h1111, 8, 2, 3, 0, 0, 0, 1, 1, 0, 3'b010);
        step();
        ForwardAE = 2'b01; ForwardBE = 2'b01; ResultW = 32'hDEADBEEF;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        step();
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
        chk("fwdB WriteDataM", WriteDataM, 32'hDEADBEEF);
        chk("fwdB ALUOutM", ALUOutM, 32'hDEADBEF7);
        chk("fwdB MemWriteM", {31'd0, MemWriteM}, 1);
        chk("fwdB RegWriteM", {31'd0, RegWriteM}, 0);

        // Forward select 11 falls back to the register operands.
        set_d(6, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3'b110);
        step();
        ForwardAE = 2'b11; ForwardBE = 2'b11; ResultW = 32'h55;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        step();
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
        chk("fwd11 ALUOutM", ALUOutM, 4);
        chk("fwd11 WriteDataM", WriteDataM, 2);

        // Flush: EX instruction completes, a bubble enters EX.
        set_d(3, 4, 0, 1, 2, 5, 1, 1, 0, 0, 1, 3'b010);
        step();
        FlushE = 1'b1;
        set_d(7, 7, 0, 3, 4, 6, 1, 0, 1, 0, 1, 3'b010);
        step();
        FlushE = 1'b0;
        chk("flush RsE", {27'd0, RsE}, 0);
        chk("flush RtE", {27'd0, RtE}, 0);
        chk("flush RegWriteE", {31'd0, RegWriteE}, 0);
        chk("flush WriteRegE", {27'd0, WriteRegE}, 0);
        chk("flush older ALUOutM", ALUOutM, 7);
        chk("flush older RegWriteM", {31'd0, RegWriteM}, 1);
        chk("flush older MemtoRegM", {31'd0, MemtoRegM}, 1);
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        step();
        chk("bubble RegWriteM", {31'd0, RegWriteM}, 0);
        chk("bubble MemWriteM", {31'd0, MemWriteM}, 0);
        chk("bubble ALUOutM", ALUOutM, 0);

        // Asynchronous reset with both stages occupied.
        set_d(1, 2, 0, 4, 5, 6, 1, 1, 1, 0, 1, 3'b010);
        step();
        set_d(8, 9, 0, 7, 8, 10, 1, 1, 0, 0, 1, 3'b001);
        step();
        chk("pre-rst MemtoRegM", {31'd0, MemtoRegM}, 1);
        chk("pre-rst RegWriteE", {31'd0, RegWriteE}, 1);
        #2;
        RST = 1'b1;
        #1;
        chk_all_zero("async-rst");
        step();
        chk_all_zero("held-rst");
        #2;
        RST = 1'b0;
        set_d(40, 2, 0, 1, 2, 20, 1, 0, 0, 0, 1, 3'b110);
        step();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
        step();
        chk("post-rst ALUOutM", ALUOutM, 38);
        chk("post-rst WriteRegM", {27'd0, WriteRegM}, 20);
        chk("post-rst RegWriteM", {31'd0, RegWriteM}, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
